// File: rtl/player_scheduler_pkg.sv
// rtl/player_scheduler_pkg.sv - shared constants and types for the player scheduler
package player_scheduler_pkg;

    localparam int ACTIVE_WIDTH_DEFAULT = 160;
    localparam int NEAR_SPACING_DEFAULT = 16;
    localparam int MED_SPACING_DEFAULT  = 32;

    localparam logic [2:0] ADDR_P0_GRP  = 3'd0;
    localparam logic [2:0] ADDR_P0_HPOS = 3'd1;
    localparam logic [2:0] ADDR_P0_CTRL = 3'd2;
    localparam logic [2:0] ADDR_P1_GRP  = 3'd3;
    localparam logic [2:0] ADDR_P1_HPOS = 3'd4;
    localparam logic [2:0] ADDR_P1_CTRL = 3'd5;
    localparam logic [2:0] ADDR_CLRCOL  = 3'd6;

    // CTRL field positions; bits [7:5] are not stored
    localparam int CTRL_WIDTH_LSB   = 0;
    localparam int CTRL_WIDTH_MSB   = 1;
    localparam int CTRL_COPIES_LSB  = 2;
    localparam int CTRL_COPIES_MSB  = 3;
    localparam int CTRL_REFLECT_BIT = 4;
    localparam int CTRL_BITS        = 5;

    localparam logic [1:0] COPIES_ONE        = 2'd0;
    localparam logic [1:0] COPIES_TWO_NEAR   = 2'd1;
    localparam logic [1:0] COPIES_TWO_MED    = 2'd2;
    localparam logic [1:0] COPIES_THREE_NEAR = 2'd3;

    typedef enum logic {
        LINE_IDLE   = 1'b0,
        LINE_ACTIVE = 1'b1
    } line_state_t;

endpackage

// File: rtl/player_slot.sv
// rtl/player_slot.sv - working/shadow registers and copy strobe generation for one player
module player_slot
    import player_scheduler_pkg::*;
#(
    parameter int ACTIVE_WIDTH = ACTIVE_WIDTH_DEFAULT,
    parameter int NEAR_SPACING = NEAR_SPACING_DEFAULT,
    parameter int MED_SPACING  = MED_SPACING_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       line_start,
    input  logic       grp_we,
    input  logic       hpos_we,
    input  logic       ctrl_we,
    input  logic [7:0] wr_data,
    input  logic       match_en,
    input  logic [7:0] x,
    output logic       strobe,
    output logic [7:0] data,
    output logic [1:0] width,
    output logic       direction
);

    // 9-bit target arithmetic so HPOS + 2*NEAR never wraps back into the visible range
    localparam logic [8:0] NEAR9  = 9'(NEAR_SPACING);
    localparam logic [8:0] MED9   = 9'(MED_SPACING);
    localparam logic [8:0] LIMIT9 = 9'(ACTIVE_WIDTH);

    logic [7:0]           grp_w, hpos_w, grp_s, hpos_s;
    logic [CTRL_BITS-1:0] ctrl_w, ctrl_s;
    logic [1:0]           copies;
    logic [8:0]           x9, t0, t1, t2;
    logic                 hit0, hit1, hit2, hit;

    // Working regs take CPU writes; shadows reload at line start, preferring a same-cycle write
    always_ff @(posedge clk) begin
        if (reset) begin
            grp_w  <= '0;
            hpos_w <= '0;
            ctrl_w <= '0;
            grp_s  <= '0;
            hpos_s <= '0;
            ctrl_s <= '0;
            strobe <= 1'b0;
        end else begin
            if (grp_we)  grp_w  <= wr_data;
            if (hpos_we) hpos_w <= wr_data;
            if (ctrl_we) ctrl_w <= wr_data[CTRL_BITS-1:0];
            if (line_start) begin
                grp_s  <= grp_we  ? wr_data : grp_w;
                hpos_s <= hpos_we ? wr_data : hpos_w;
                ctrl_s <= ctrl_we ? wr_data[CTRL_BITS-1:0] : ctrl_w;
            end
            strobe <= hit;
        end
    end

    // Per-copy targets; any copy landing at or beyond the line end is dropped
    always_comb begin
        copies = ctrl_s[CTRL_COPIES_MSB:CTRL_COPIES_LSB];
        x9     = {1'b0, x};
        t0     = {1'b0, hpos_s};
        t1     = t0 + ((copies == COPIES_TWO_MED) ? MED9 : NEAR9);
        t2     = t0 + (NEAR9 << 1);
        hit0   = (t0 == x9) && (t0 < LIMIT9);
        hit1   = (copies != COPIES_ONE) && (t1 == x9) && (t1 < LIMIT9);
        hit2   = (copies == COPIES_THREE_NEAR) && (t2 == x9) && (t2 < LIMIT9);
        hit    = match_en && (hit0 || hit1 || hit2);
    end

    assign data      = grp_s;
    assign width     = ctrl_s[CTRL_WIDTH_MSB:CTRL_WIDTH_LSB];
    assign direction = ctrl_s[CTRL_REFLECT_BIT];

endmodule

// File: rtl/player_scheduler.sv
// rtl/player_scheduler.sv - scanline x counter, register decode and collision latch for two players
module player_scheduler
    import player_scheduler_pkg::*;
#(
    parameter int ACTIVE_WIDTH = ACTIVE_WIDTH_DEFAULT,
    parameter int NEAR_SPACING = NEAR_SPACING_DEFAULT,
    parameter int MED_SPACING  = MED_SPACING_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       line_start,
    input  logic       pixel_tick,
    input  logic [2:0] reg_addr,
    input  logic [7:0] reg_data,
    input  logic       reg_write,
    input  logic       p0_value,
    input  logic       p1_value,
    output logic       p0_strobe,
    output logic [7:0] p0_data,
    output logic [1:0] p0_width,
    output logic       p0_direction,
    output logic       p1_strobe,
    output logic [7:0] p1_data,
    output logic [1:0] p1_width,
    output logic       p1_direction,
    output logic       collision
);

    localparam logic [7:0] X_LAST = 8'(ACTIVE_WIDTH - 1);

    line_state_t state, state_next;
    logic [7:0]  x, x_next;
    logic        match_en;
    logic        clr_col;

    // Line state and pixel counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LINE_IDLE;
            x     <= '0;
        end else begin
            state <= state_next;
            x     <= x_next;
        end
    end

    // line_start always restarts the line; ticks only advance x while active
    always_comb begin
        state_next = state;
        x_next     = x;
        if (line_start) begin
            state_next = LINE_ACTIVE;
            x_next     = '0;
        end else if (state == LINE_ACTIVE && pixel_tick) begin
            if (x == X_LAST) begin
                state_next = LINE_IDLE;
                x_next     = '0;
            end else begin
                x_next = x + 8'd1;
            end
        end
    end

    assign match_en = pixel_tick && (state == LINE_ACTIVE) && !line_start;
    assign clr_col  = reg_write && (reg_addr == ADDR_CLRCOL);

    // Sticky overlap flag; a new overlap beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset)                    collision <= 1'b0;
        else if (p0_value && p1_value) collision <= 1'b1;
        else if (clr_col)             collision <= 1'b0;
    end

    player_slot #(
        .ACTIVE_WIDTH (ACTIVE_WIDTH),
        .NEAR_SPACING (NEAR_SPACING),
        .MED_SPACING  (MED_SPACING)
    ) u_p0 (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .grp_we     (reg_write && (reg_addr == ADDR_P0_GRP)),
        .hpos_we    (reg_write && (reg_addr == ADDR_P0_HPOS)),
        .ctrl_we    (reg_write && (reg_addr == ADDR_P0_CTRL)),
        .wr_data    (reg_data),
        .match_en   (match_en),
        .x          (x),
        .strobe     (p0_strobe),
        .data       (p0_data),
        .width      (p0_width),
        .direction  (p0_direction)
    );

    player_slot #(
        .ACTIVE_WIDTH (ACTIVE_WIDTH),
        .NEAR_SPACING (NEAR_SPACING),
        .MED_SPACING  (MED_SPACING)
    ) u_p1 (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .grp_we     (reg_write && (reg_addr == ADDR_P1_GRP)),
        .hpos_we    (reg_write && (reg_addr == ADDR_P1_HPOS)),
        .ctrl_we    (reg_write && (reg_addr == ADDR_P1_CTRL)),
        .wr_data    (reg_data),
        .match_en   (match_en),
        .x          (x),
        .strobe     (p1_strobe),
        .data       (p1_data),
        .width      (p1_width),
        .direction  (p1_direction)
    );

endmodule

// File: tb/tb_player_scheduler.sv
// tb/tb_player_scheduler.sv - directed self-checking bench for player_scheduler
module tb_player_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       line_start = 1'b0;
    logic       pixel_tick = 1'b0;
    logic [2:0] reg_addr = '0;
    logic [7:0] reg_data = '0;
    logic       reg_write = 1'b0;
    logic       p0_value = 1'b0;
    logic       p1_value = 1'b0;
    logic       p0_strobe, p1_strobe, p0_direction, p1_direction, collision;
    logic [7:0] p0_data, p1_data;
    logic [1:0] p0_width, p1_width;

    int tests = 0;
    int fails = 0;

    logic [159:0] m0, m1;
    logic         any_strobe;

    always #5 clk = ~clk;

    player_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .line_start   (line_start),
        .pixel_tick   (pixel_tick),
        .reg_addr     (reg_addr),
        .reg_data     (reg_data),
        .reg_write    (reg_write),
        .p0_value     (p0_value),
        .p1_value     (p1_value),
        .p0_strobe    (p0_strobe),
        .p0_data      (p0_data),
        .p0_width     (p0_width),
        .p0_direction (p0_direction),
        .p1_strobe    (p1_strobe),
        .p1_data      (p1_data),
        .p1_width     (p1_width),
        .p1_direction (p1_direction),
        .collision    (collision)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        reg_addr  = a;
        reg_data  = d;
        reg_write = 1'b1;
        step();
        reg_write = 1'b0;
    endtask

    function automatic logic [159:0] bits(input int a, input int b, input int c);
        logic [159:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        if (c >= 0) r[c] = 1'b1;
        return r;
    endfunction

    // One full line: optional write alongside line_start, optional write alongside tick mid_at
    task automatic run_line(input logic ls_we, input logic [2:0] ls_addr, input logic [7:0] ls_data,
                            input logic mid_we, input int mid_at,
                            input logic [2:0] mid_addr, input logic [7:0] mid_data,
                            output logic [159:0] s0, output logic [159:0] s1);
        s0 = '0;
        s1 = '0;
        line_start = 1'b1;
        reg_write  = ls_we;
        reg_addr   = ls_addr;
        reg_data   = ls_data;
        step();
        line_start = 1'b0;
        reg_write  = 1'b0;
        for (int i = 0; i < 160; i++) begin
            pixel_tick = 1'b1;
            if (mid_we && i == mid_at) begin
                reg_write = 1'b1;
                reg_addr  = mid_addr;
                reg_data  = mid_data;
            end
            step();
            reg_write = 1'b0;
            s0[i] = p0_strobe;
            s1[i] = p1_strobe;
        end
        pixel_tick = 1'b0;
    endtask

    task automatic idle_ticks(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            pixel_tick = 1'b1;
            step();
            seen = seen | p0_strobe | p1_strobe;
        end
        pixel_tick = 1'b0;
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        step();
        check("rst_p0_strobe", 160'(p0_strobe), 160'(0));
        check("rst_p1_strobe", 160'(p1_strobe), 160'(0));
        check("rst_p0_data", 160'(p0_data), 160'(0));
        check("rst_p1_data", 160'(p1_data), 160'(0));
        check("rst_widths_dirs", 160'({p0_width, p1_width, p0_direction, p1_direction}), 160'(0));
        check("rst_collision", 160'(collision), 160'(0));

        idle_ticks(20, any_strobe);
        check("idle_no_line_strobe", 160'(any_strobe), 160'(0));

        write_reg(3'd0, 8'hA5);
        write_reg(3'd1, 8'd10);
        write_reg(3'd2, 8'h00);
        write_reg(3'd4, 8'd200);
        write_reg(3'd5, 8'h0C);
        check("shadow_before_line", 160'(p0_data), 160'(0));
        run_line(1'b0, 3'd0, 8'd0, 1'b0, 0, 3'd0, 8'd0, m0, m1);
        check("p0_single_at10", m0, bits(10, -1, -1));
        check("p1_hpos200_none", m1, bits(-1, -1, -1));
        check("p0_data_shadow", 160'(p0_data), 160'(8'hA5));
        idle_ticks(20, any_strobe);
        check("ticks_after_line_ignored", 160'(any_strobe), 160'(0));

        write_reg(3'd2, 8'h08);
        write_reg(3'd4, 8'd100);
        write_reg(3'd5, 8'h1D);
        run_line(1'b0, 3'd0, 8'd0, 1'b0, 0, 3'd0, 8'd0, m0, m1);
        check("p0_med_10_42", m0, bits(10, 42, -1));
        check("p1_three_100", m1, bits(100, 116, 132));
        check("p1_width", 160'(p1_width), 160'(1));
        check("p1_direction", 160'(p1_direction), 160'(1));
        check("p0_width_dir", 160'({p0_width, p0_direction}), 160'(0));

        write_reg(3'd4, 8'd140);
        write_reg(3'd1, 8'd150);
        write_reg(3'd2, 8'h04);
        run_line(1'b0, 3'd0, 8'd0, 1'b0, 0, 3'd0, 8'd0, m0, m1);
        check("p0_two_near_150", m0, bits(150, -1, -1));
        check("p1_three_140_clip", m1, bits(140, 156, -1));

        run_line(1'b0, 3'd0, 8'd0, 1'b1, 5, 3'd1, 8'd20, m0, m1);
        check("midline_write_no_effect", m0, bits(150, -1, -1));
        check("midline_p1_unchanged", m1, bits(140, 156, -1));

        run_line(1'b1, 3'd1, 8'd30, 1'b0, 0, 3'd0, 8'd0, m0, m1);
        check("ls_write_new_value", m0, bits(30, 46, -1));

        p0_value = 1'b1;
        p1_value = 1'b1;
        step();
        p1_value = 1'b0;
        check("col_set", 160'(collision), 160'(1));
        step();
        p0_value = 1'b0;
        check("col_sticky", 160'(collision), 160'(1));
        write_reg(3'd7, 8'hFF);
        check("addr7_ignored", 160'(collision), 160'(1));
        write_reg(3'd6, 8'h00);
        check("col_cleared", 160'(collision), 160'(0));
        p0_value = 1'b1;
        p1_value = 1'b1;
        write_reg(3'd6, 8'h00);
        p0_value = 1'b0;
        p1_value = 1'b0;
        check("col_set_beats_clear", 160'(collision), 160'(1));

        line_start = 1'b1;
        step();
        line_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            pixel_tick = 1'b1;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        pixel_tick = 1'b0;
        check("rst_mid_no_strobe", 160'(p0_strobe), 160'(0));
        check("rst_mid_p0_data", 160'(p0_data), 160'(0));
        check("rst_mid_collision", 160'(collision), 160'(0));
        check("rst_mid_p1_width_dir", 160'({p1_width, p1_direction}), 160'(0));
        idle_ticks(40, any_strobe);
        check("rst_mid_returns_idle", 160'(any_strobe), 160'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
